// File: rtl/lsb_queue_if.sv
// Memory-controller request/response bus of the load/store queue.
// master: queue side (drives request, gets done/rdata); slave: memctrl side.
interface lsb_queue_if;
  logic        mc_ena;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [1:0]  mc_len;
  logic        mc_sext;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;

  modport master (
    output mc_ena, mc_wr, mc_addr, mc_len, mc_sext, mc_wdata,
    input  mc_done, mc_rdata
  );

  modport slave (
    input  mc_ena, mc_wr, mc_addr, mc_len, mc_sext, mc_wdata,
    output mc_done, mc_rdata
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store queue: snoops CDB, issues loads and committed stores
// to memctrl (mc bus), broadcasts load results; clk/rst/rdy/lsb_rb control,
// id_* push, cdb_* snoop, st_rdy/st_idx/rob_commit_st ROB handshake, ld_out_*.
module lsb_queue #(
  parameter int DEPTH_BIT   = 4,
  parameter int ROB_BIT     = 4,
  parameter int NUM_CDB     = 2,
  parameter int FULL_MARGIN = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       lsb_rb,
  output logic                       lsb_full,
  output logic                       lsb_empty,
  input  logic                       id_valid,
  input  logic                       id_isld,
  input  logic [1:0]                 id_len,
  input  logic                       id_sext,
  input  logic [ROB_BIT-1:0]         id_src1,
  input  logic [ROB_BIT-1:0]         id_src2,
  input  logic [31:0]                id_val1,
  input  logic [31:0]                id_val2,
  input  logic [31:0]                id_imm,
  input  logic [ROB_BIT-1:0]         id_rob_idx,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_src,
  input  logic [NUM_CDB*32-1:0]      cdb_val,
  output logic                       st_rdy,
  output logic [ROB_BIT-1:0]         st_idx,
  input  logic                       rob_commit_st,
  lsb_queue_if.master                mc,
  output logic                       ld_out_valid,
  output logic [ROB_BIT-1:0]         ld_out_src,
  output logic [31:0]                ld_out_val
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam int FULL_I = DEPTH - FULL_MARGIN;
  localparam logic [DEPTH_BIT:0] FULL_AT = FULL_I[DEPTH_BIT:0];

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;
  state_t state, state_nx;

  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     isld;
  logic [DEPTH-1:0]     sext;
  logic [1:0]           len  [DEPTH];
  logic [ROB_BIT-1:0]   src1 [DEPTH];
  logic [ROB_BIT-1:0]   src2 [DEPTH];
  logic [ROB_BIT-1:0]   dest [DEPTH];
  logic [31:0]          val1 [DEPTH];
  logic [31:0]          val2 [DEPTH];
  logic [31:0]          imm  [DEPTH];
  logic [DEPTH_BIT-1:0] head, tail;
  logic [DEPTH_BIT:0]   count;
  logic [ROB_BIT-1:0]   cur_dest;

  logic pop_ld, pop_st, pop, push, keep_wr;

  // Resolve a tag against the CDB; lowest matching channel wins.
  function automatic logic [ROB_BIT+31:0] grab(
    input logic [ROB_BIT-1:0] s,
    input logic [31:0]        v
  );
    logic [ROB_BIT+31:0] r;
    r = {s, v};
    if (s != '0)
      for (int k = NUM_CDB - 1; k >= 0; k--)
        if (cdb_valid[k] && cdb_src[k*ROB_BIT +: ROB_BIT] == s)
          r = {{ROB_BIT{1'b0}}, cdb_val[k*32 +: 32]};
    return r;
  endfunction

  assign lsb_empty = (count == '0);
  assign lsb_full  = (state == DRAIN) || (count >= FULL_AT);

  assign st_rdy = (state == IDLE) && busy[head] && !isld[head] &&
                  (src1[head] == '0) && (src2[head] == '0);
  assign st_idx = st_rdy ? dest[head] : '0;

  assign pop_ld = rdy && !lsb_rb && (state == IDLE) && busy[head] &&
                  isld[head] && (src1[head] == '0);
  assign pop_st = rdy && !lsb_rb && st_rdy && rob_commit_st;
  assign pop    = pop_ld || pop_st;
  assign push   = id_valid && !lsb_rb && (state != DRAIN);

  // A store write already on the bus must finish even across a flush.
  assign keep_wr = ((state == STORE) || (state == DRAIN)) && !mc.mc_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (pop_ld)      state_nx = LOAD;
          else if (pop_st) state_nx = STORE;
        end
        LOAD:  if (lsb_rb || mc.mc_done) state_nx = IDLE;
        STORE: begin
          if (mc.mc_done)  state_nx = IDLE;
          else if (lsb_rb) state_nx = DRAIN;
        end
        DRAIN: if (mc.mc_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      cur_dest     <= '0;
      mc.mc_ena    <= 1'b0;
      mc.mc_wr     <= 1'b0;
      mc.mc_addr   <= '0;
      mc.mc_len    <= '0;
      mc.mc_sext   <= 1'b0;
      mc.mc_wdata  <= '0;
      ld_out_valid <= 1'b0;
      ld_out_src   <= '0;
      ld_out_val   <= '0;
    end else if (rdy) begin
      ld_out_valid <= 1'b0;
      if (lsb_rb) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        if (!keep_wr) begin
          mc.mc_ena   <= 1'b0;
          mc.mc_wr    <= 1'b0;
          mc.mc_addr  <= '0;
          mc.mc_wdata <= '0;
          ld_out_val  <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i]) begin
            {src1[i], val1[i]} <= grab(src1[i], val1[i]);
            {src2[i], val2[i]} <= grab(src2[i], val2[i]);
          end
        end
        if (push) begin
          busy[tail] <= 1'b1;
          isld[tail] <= id_isld;
          sext[tail] <= id_sext;
          len[tail]  <= id_len;
          imm[tail]  <= id_imm;
          dest[tail] <= id_rob_idx;
          {src1[tail], val1[tail]} <= grab(id_src1, id_val1);
          {src2[tail], val2[tail]} <= grab(id_src2, id_val2);
          tail <= tail + 1'b1;
        end
        if (pop) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
        if (pop) begin
          mc.mc_ena  <= 1'b1;
          mc.mc_wr   <= pop_st;
          mc.mc_addr <= val1[head] + imm[head];
          mc.mc_len  <= len[head];
          mc.mc_sext <= sext[head];
          cur_dest   <= dest[head];
          if (pop_st) mc.mc_wdata <= val2[head];
        end
        if (mc.mc_done) begin
          mc.mc_ena <= 1'b0;
          if (state == LOAD) begin
            ld_out_valid <= 1'b1;
            ld_out_src   <= cur_dest;
            ld_out_val   <= mc.mc_rdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lsb_queue.sv
// Directed scoreboard bench for lsb_queue: stimulus queues expected memory
// requests and load results; a negedge monitor pops and compares them.
module tb_lsb_queue;
  logic        clk = 1'b0;
  logic        rst, rdy, lsb_rb;
  logic        lsb_full, lsb_empty;
  logic        id_valid, id_isld, id_sext;
  logic [1:0]  id_len;
  logic [3:0]  id_src1, id_src2, id_rob_idx;
  logic [31:0] id_val1, id_val2, id_imm;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_src;
  logic [63:0] cdb_val;
  logic        st_rdy;
  logic [3:0]  st_idx;
  logic        rob_commit_st;
  logic        ld_out_valid;
  logic [3:0]  ld_out_src;
  logic [31:0] ld_out_val;

  lsb_queue_if mcif ();

  lsb_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .lsb_rb(lsb_rb),
    .lsb_full(lsb_full), .lsb_empty(lsb_empty),
    .id_valid(id_valid), .id_isld(id_isld), .id_len(id_len),
    .id_sext(id_sext), .id_src1(id_src1), .id_src2(id_src2),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
    .id_rob_idx(id_rob_idx),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .st_rdy(st_rdy), .st_idx(st_idx), .rob_commit_st(rob_commit_st),
    .mc(mcif),
    .ld_out_valid(ld_out_valid), .ld_out_src(ld_out_src),
    .ld_out_val(ld_out_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic        sext;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [3:0]  src;
    logic [31:0] val;
  } ld_t;

  req_t req_q[$];
  ld_t  ld_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic ena_seen = 1'b0;
  logic ld_seen  = 1'b0;

  always @(negedge clk) begin
    req_t r;
    ld_t  l;
    if (!rst) begin
      if (mcif.mc_ena && !ena_seen) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h wr %b want none",
                   mcif.mc_addr, mcif.mc_wr);
        end else begin
          r = req_q.pop_front();
          chk("req_wr", 32'(mcif.mc_wr), 32'(r.wr));
          chk("req_addr", mcif.mc_addr, r.addr);
          chk("req_len", 32'(mcif.mc_len), 32'(r.len));
          chk("req_sext", 32'(mcif.mc_sext), 32'(r.sext));
          if (r.wr) chk("req_wdata", mcif.mc_wdata, r.wdata);
        end
      end
      if (ld_out_valid && !ld_seen) begin
        if (ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ld: got src %h val %h want none",
                   ld_out_src, ld_out_val);
        end else begin
          l = ld_q.pop_front();
          chk("ld_src", 32'(ld_out_src), 32'(l.src));
          chk("ld_val", ld_out_val, l.val);
        end
      end
    end
    ena_seen = mcif.mc_ena && !rst;
    ld_seen  = ld_out_valid && !rst;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic ld, input logic [1:0] ln,
                        input logic sx, input logic [3:0] s1,
                        input logic [31:0] v1, input logic [3:0] s2,
                        input logic [31:0] v2, input logic [31:0] im,
                        input logic [3:0] rob);
    id_isld = ld; id_len = ln; id_sext = sx;
    id_src1 = s1; id_val1 = v1; id_src2 = s2; id_val2 = v2;
    id_imm = im; id_rob_idx = rob;
  endtask

  task automatic push(input logic ld, input logic [1:0] ln,
                      input logic sx, input logic [3:0] s1,
                      input logic [31:0] v1, input logic [3:0] s2,
                      input logic [31:0] v2, input logic [31:0] im,
                      input logic [3:0] rob);
    set_id(ld, ln, sx, s1, v1, s2, v2, im, rob);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
  endtask

  task automatic wait_ena(input string name);
    int n = 0;
    while (!mcif.mc_ena && n < 20) begin
      tick();
      n++;
    end
    if (!mcif.mc_ena) begin
      checks++;
      errors++;
      $display("FAIL %s: got mc_ena 0 want 1 within 20 cycles", name);
    end
  endtask

  task automatic wait_st(input string name);
    int n = 0;
    while (!st_rdy && n < 20) begin
      tick();
      n++;
    end
    if (!st_rdy) begin
      checks++;
      errors++;
      $display("FAIL %s: got st_rdy 0 want 1 within 20 cycles", name);
    end
  endtask

  task automatic mem_done(input logic [31:0] d);
    mcif.mc_done  = 1'b1;
    mcif.mc_rdata = d;
    tick();
    mcif.mc_done  = 1'b0;
    mcif.mc_rdata = '0;
  endtask

  task automatic commit_store(input string name);
    wait_st(name);
    rob_commit_st = 1'b1;
    tick();
    rob_commit_st = 1'b0;
    wait_ena(name);
    tick();
    mem_done('0);
    chk({name, "_ena_off"}, 32'(mcif.mc_ena), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; lsb_rb = 1'b0;
    id_valid = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb_valid = '0; cdb_src = '0; cdb_val = '0;
    rob_commit_st = 1'b0;
    mcif.mc_done = 1'b0; mcif.mc_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_empty", 32'(lsb_empty), 32'd1);
    chk("rst_full", 32'(lsb_full), 32'd0);
    chk("rst_ena", 32'(mcif.mc_ena), 32'd0);
    chk("rst_addr", mcif.mc_addr, 32'd0);
    chk("rst_ldv", 32'(ld_out_valid), 32'd0);
    chk("rst_st_rdy", 32'(st_rdy), 32'd0);

    // LW base 0x100 + 4, data returned three cycles after issue
    req_q.push_back('{1'b0, 32'h104, 2'd3, 1'b0, 32'h0});
    ld_q.push_back('{4'd3, 32'hDEADBEEF});
    push(1, 3, 0, 0, 32'h100, 0, 0, 32'h4, 3);
    wait_ena("lw_issue");
    tick();
    tick();
    mem_done(32'hDEADBEEF);
    chk("lw_ena_off", 32'(mcif.mc_ena), 32'd0);
    chk("lw_ldv", 32'(ld_out_valid), 32'd1);
    tick();
    chk("lw_ldv_pulse", 32'(ld_out_valid), 32'd0);

    // Store data bypassed from CDB channel 1 on the push cycle
    cdb_valid = 2'b10; cdb_src = {4'd5, 4'd0}; cdb_val = {32'h7, 32'h0};
    req_q.push_back('{1'b1, 32'h210, 2'd3, 1'b0, 32'h7});
    push(0, 3, 0, 0, 32'h200, 5, 0, 32'h10, 6);
    cdb_valid = '0;
    chk("byp_st_rdy", 32'(st_rdy), 32'd1);
    chk("byp_st_idx", 32'(st_idx), 32'd6);
    commit_store("byp_st");

    // Both channels carry the tag: channel 0 value wins
    cdb_valid = 2'b11; cdb_src = {4'd5, 4'd5}; cdb_val = {32'h9, 32'h8};
    req_q.push_back('{1'b1, 32'h300, 2'd1, 1'b0, 32'h8});
    push(0, 1, 0, 0, 32'h300, 5, 0, 32'h0, 7);
    cdb_valid = '0;
    commit_store("prio_st");

    // Stored tag picked up later by snooping
    req_q.push_back('{1'b1, 32'h408, 2'd0, 1'b0, 32'h55});
    push(0, 0, 0, 0, 32'h400, 7, 0, 32'h8, 8);
    tick();
    chk("snoop_wait", 32'(st_rdy), 32'd0);
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h55};
    tick();
    cdb_valid = '0;
    chk("snoop_rdy", 32'(st_rdy), 32'd1);
    commit_store("snoop_st");

    // Fill to the full threshold, pointers wrap past 15
    for (int j = 0; j < 14; j++)
      req_q.push_back('{1'b1, 32'h2000 + 32'(4 * j), 2'd3, 1'b0, 32'(j)});
    push(0, 3, 0, 0, 32'h2000, 0, 32'd0, 32'd0, 1);
    for (int j = 1; j < 13; j++) begin
      push(0, 3, 0, 9, 0, 0, 32'(j), 32'(4 * j), 4'(j + 1));
      if (j == 11) chk("fill12_full", 32'(lsb_full), 32'd0);
    end
    chk("fill13_full", 32'(lsb_full), 32'd1);
    chk("fill_st_rdy", 32'(st_rdy), 32'd1);
    set_id(0, 3, 0, 9, 0, 0, 32'd13, 32'd52, 14);
    id_valid = 1'b1;
    rob_commit_st = 1'b1;
    tick();
    id_valid = 1'b0;
    rob_commit_st = 1'b0;
    chk("poppush_full", 32'(lsb_full), 32'd1);
    wait_ena("fill_first");
    tick();
    mem_done('0);
    cdb_valid = 2'b10; cdb_src = {4'd9, 4'd0}; cdb_val = {32'h2000, 32'h0};
    tick();
    cdb_valid = '0;
    for (int j = 1; j < 14; j++) begin
      commit_store("drain_st");
      if (j == 1) chk("drain12_full", 32'(lsb_full), 32'd0);
    end
    chk("fill_empty", 32'(lsb_empty), 32'd1);

    // Rollback while a store write is outstanding
    req_q.push_back('{1'b1, 32'h500, 2'd3, 1'b0, 32'hA5});
    push(0, 3, 0, 0, 32'h500, 0, 32'hA5, 0, 2);
    push(0, 3, 0, 0, 32'h600, 0, 32'hB6, 0, 3);
    rob_commit_st = 1'b1;
    tick();
    rob_commit_st = 1'b0;
    wait_ena("rbst_issue");
    tick();
    lsb_rb = 1'b1;
    tick();
    lsb_rb = 1'b0;
    chk("rbst_empty", 32'(lsb_empty), 32'd1);
    chk("rbst_ena", 32'(mcif.mc_ena), 32'd1);
    chk("rbst_full", 32'(lsb_full), 32'd1);
    chk("rbst_addr", mcif.mc_addr, 32'h500);
    push(1, 3, 0, 0, 32'h700, 0, 0, 0, 9);
    chk("rbst_nopush", 32'(lsb_empty), 32'd1);
    tick();
    chk("rbst_hold", 32'(mcif.mc_ena), 32'd1);
    mem_done('0);
    chk("rbst_ena_off", 32'(mcif.mc_ena), 32'd0);
    chk("rbst_full_off", 32'(lsb_full), 32'd0);
    repeat (4) tick();
    chk("rbst_idle", 32'(mcif.mc_ena), 32'd0);

    // Rollback while a load is outstanding
    req_q.push_back('{1'b0, 32'h700, 2'd3, 1'b0, 32'h0});
    push(1, 3, 0, 0, 32'h700, 0, 0, 0, 4);
    wait_ena("rbld_issue");
    tick();
    lsb_rb = 1'b1;
    tick();
    lsb_rb = 1'b0;
    chk("rbld_ena_off", 32'(mcif.mc_ena), 32'd0);
    repeat (4) tick();
    req_q.push_back('{1'b0, 32'h810, 2'd0, 1'b1, 32'h0});
    ld_q.push_back('{4'd5, 32'h80});
    push(1, 0, 1, 0, 32'h800, 0, 0, 32'h10, 5);
    wait_ena("rbld_next");
    tick();
    mem_done(32'h80);
    tick();

    // Stall mid-load with CDB and push activity that must be ignored
    req_q.push_back('{1'b0, 32'h904, 2'd3, 1'b0, 32'h0});
    ld_q.push_back('{4'd8, 32'h1234});
    push(1, 3, 0, 0, 32'h900, 0, 0, 32'h4, 8);
    push(0, 3, 0, 0, 32'hA00, 4, 0, 0, 10);
    wait_ena("stall_issue");
    rdy = 1'b0;
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd4}; cdb_val = {32'h0, 32'h99};
    set_id(1, 3, 0, 0, 32'hB00, 0, 0, 0, 11);
    id_valid = 1'b1;
    repeat (5) tick();
    chk("stall_ena", 32'(mcif.mc_ena), 32'd1);
    chk("stall_addr", mcif.mc_addr, 32'h904);
    rdy = 1'b1;
    cdb_valid = '0;
    id_valid = 1'b0;
    tick();
    mem_done(32'h1234);
    tick();
    chk("stall_nosnoop", 32'(st_rdy), 32'd0);
    req_q.push_back('{1'b1, 32'hA00, 2'd3, 1'b0, 32'h99});
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd4}; cdb_val = {32'h0, 32'h99};
    tick();
    cdb_valid = '0;
    commit_store("stall_st");
    chk("stall_empty", 32'(lsb_empty), 32'd1);

    repeat (3) tick();
    chk("req_left", 32'(req_q.size()), 32'd0);
    chk("ld_left", 32'(ld_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
